// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA hs/vs/blank stream, measures sync timing,
// and tracks lock against the expected timing with a SEARCH/ACQUIRE/LOCKED FSM.
module vga_sync_decoder #(
   parameter int EXP_H_TOTAL = 800,
   parameter int EXP_H_SYNC  = 96,
   parameter int EXP_V_TOTAL = 525,
   parameter int EXP_V_SYNC  = 2,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk25,
   input  logic       rstN,
   input  logic       hs,
   input  logic       vs,
   input  logic       blankN,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pixelValid,
   output logic       lineStart,
   output logic       frameStart,
   output logic [9:0] hTotalMeas,
   output logic [9:0] hSyncMeas,
   output logic [9:0] vTotalMeas,
   output logic [9:0] vSyncMeas,
   output logic       locked,
   output logic       lossOfLock
);

   localparam logic [9:0]  CNT_MAX   = 10'd1023;
   localparam logic [10:0] H_TOTAL_X = 11'(EXP_H_TOTAL);
   localparam logic [9:0]  H_SYNC_X  = 10'(EXP_H_SYNC);
   localparam logic [10:0] V_TOTAL_X = 11'(EXP_V_TOTAL);
   localparam logic [9:0]  V_SYNC_X  = 10'(EXP_V_SYNC);
   localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t      state_reg;
   logic        hs_d, vs_d, b_d;
   logic [9:0]  h_cnt, h_low_cnt, line_cnt, vs_line_cnt;
   logic        line_bad;
   logic [7:0]  good_cnt;

   logic        h_fall, h_rise, v_fall, v_rise, b_fall, h_sat;
   logic [10:0] h_total_now, line_total, vs_total;
   logic        h_bad_fall, h_bad_rise, frame_good;
   logic [7:0]  good_inc;

   assign h_fall = hs_d & ~hs;
   assign h_rise = ~hs_d & hs;
   assign v_fall = vs_d & ~vs;
   assign v_rise = ~vs_d & vs;
   assign b_fall = b_d & ~blankN;
   assign h_sat  = (h_cnt == CNT_MAX);

   assign h_total_now = {1'b0, h_cnt} + 11'd1;
   assign line_total  = {1'b0, line_cnt} + {10'd0, h_fall};
   assign vs_total    = {1'b0, vs_line_cnt} + {10'd0, h_fall};

   // The line closed by a concurrent hs fall belongs to the frame being judged.
   assign h_bad_fall = h_fall && (h_total_now != H_TOTAL_X);
   assign h_bad_rise = h_rise && (h_low_cnt != H_SYNC_X);
   assign frame_good = !(line_bad || h_bad_fall || h_bad_rise) &&
                       (line_total == V_TOTAL_X) && (vSyncMeas == V_SYNC_X);
   assign good_inc   = good_cnt + 8'd1;

   assign pixelValid = b_d;

   always_ff @(posedge clk25) begin
      if (!rstN) begin
         hs_d        <= 1'b1;
         vs_d        <= 1'b1;
         b_d         <= 1'b0;
         lineStart   <= 1'b0;
         frameStart  <= 1'b0;
         h_cnt       <= '0;
         h_low_cnt   <= '0;
         line_cnt    <= '0;
         vs_line_cnt <= '0;
         hTotalMeas  <= '0;
         hSyncMeas   <= '0;
         vTotalMeas  <= '0;
         vSyncMeas   <= '0;
         x           <= '0;
         y           <= '0;
         line_bad    <= 1'b0;
      end else begin
         hs_d       <= hs;
         vs_d       <= vs;
         b_d        <= blankN;
         lineStart  <= h_fall;
         frameStart <= v_fall;

         if (h_fall) begin
            h_cnt      <= '0;
            hTotalMeas <= h_sat ? CNT_MAX : h_total_now[9:0];
         end else if (!h_sat) begin
            h_cnt <= h_cnt + 10'd1;
         end

         if (h_rise) begin
            hSyncMeas <= h_low_cnt;
            h_low_cnt <= '0;
         end else if (!hs && h_low_cnt != CNT_MAX) begin
            h_low_cnt <= h_low_cnt + 10'd1;
         end

         if (v_fall) begin
            vTotalMeas <= line_total[10] ? CNT_MAX : line_total[9:0];
            line_cnt   <= '0;
         end else if (h_fall && line_cnt != CNT_MAX) begin
            line_cnt <= line_cnt + 10'd1;
         end

         // An hs fall in the vs rise cycle still happened while vs was low.
         if (v_rise) begin
            vSyncMeas   <= vs_total[10] ? CNT_MAX : vs_total[9:0];
            vs_line_cnt <= '0;
         end else if (h_fall && !vs_d && vs_line_cnt != CNT_MAX) begin
            vs_line_cnt <= vs_line_cnt + 10'd1;
         end

         if (!blankN)
            x <= '0;
         else if (!b_d)
            x <= '0;
         else if (x != CNT_MAX)
            x <= x + 10'd1;

         if (v_fall)
            y <= '0;
         else if (b_fall && y != CNT_MAX)
            y <= y + 10'd1;

         if (v_fall)
            line_bad <= 1'b0;
         else if (h_bad_fall || h_bad_rise)
            line_bad <= 1'b1;
      end
   end

   always_ff @(posedge clk25) begin
      if (!rstN) begin
         state_reg  <= SEARCH;
         good_cnt   <= '0;
         locked     <= 1'b0;
         lossOfLock <= 1'b0;
      end else begin
         lossOfLock <= 1'b0;
         case (state_reg)
            SEARCH: begin
               if (v_fall) begin
                  state_reg <= ACQUIRE;
                  good_cnt  <= '0;
               end
            end
            ACQUIRE: begin
               if (h_sat) begin
                  state_reg <= SEARCH;
               end else if (v_fall) begin
                  if (frame_good) begin
                     good_cnt <= good_inc;
                     if (good_inc >= LOCK_N) begin
                        state_reg <= LOCKED;
                        locked    <= 1'b1;
                     end
                  end else begin
                     good_cnt <= '0;
                  end
               end
            end
            LOCKED: begin
               if (h_sat || (v_fall && !frame_good)) begin
                  state_reg  <= SEARCH;
                  locked     <= 1'b0;
                  lossOfLock <= 1'b1;
               end
            end
            default: begin
               state_reg <= SEARCH;
               locked    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled raster: 64 cycles x 24 lines,
// hs 8 cycles, vs 2 lines, active window 40 x 16 (columns 16..55, lines 4..19).
module tb_vga_sync_decoder;

   localparam int HT = 64;
   localparam int HS = 8;
   localparam int VT = 24;
   localparam int VS = 2;

   logic       clk25 = 1'b0;
   logic       rstN = 1'b0;
   logic       hs = 1'b1;
   logic       vs = 1'b1;
   logic       blankN = 1'b0;
   logic [9:0] x, y, hTotalMeas, hSyncMeas, vTotalMeas, vSyncMeas;
   logic       pixelValid, lineStart, frameStart, locked, lossOfLock;
   logic [64:0] out_vec;

   int vectors = 0;
   int miscompares = 0;
   int pv_count, x_max, y_max, ls_count, fs_count, lol_count, lock_at;
   int y_at_fs, vt_at_fs;
   logic fs_with_ls;
   logic locked_q = 1'b0;

   vga_sync_decoder #(
      .EXP_H_TOTAL(HT), .EXP_H_SYNC(HS), .EXP_V_TOTAL(VT), .EXP_V_SYNC(VS), .LOCK_FRAMES(2)
   ) dut (
      .clk25(clk25), .rstN(rstN), .hs(hs), .vs(vs), .blankN(blankN),
      .x(x), .y(y), .pixelValid(pixelValid), .lineStart(lineStart), .frameStart(frameStart),
      .hTotalMeas(hTotalMeas), .hSyncMeas(hSyncMeas), .vTotalMeas(vTotalMeas),
      .vSyncMeas(vSyncMeas), .locked(locked), .lossOfLock(lossOfLock)
   );

   assign out_vec = {x, y, pixelValid, lineStart, frameStart, hTotalMeas, hSyncMeas,
                     vTotalMeas, vSyncMeas, locked, lossOfLock};

   always #20 clk25 = ~clk25;

   task automatic sample();
      pv_count += int'(pixelValid);
      if (pixelValid) begin
         if (int'(x) > x_max) x_max = int'(x);
         if (int'(y) > y_max) y_max = int'(y);
      end
      if (lineStart) ls_count++;
      if (frameStart) begin
         fs_count++;
         fs_with_ls = lineStart;
         y_at_fs = int'(y);
         vt_at_fs = int'(vTotalMeas);
      end
      if (lossOfLock) lol_count++;
      if (locked && !locked_q) lock_at = fs_count;
      locked_q = locked;
   endtask

   task automatic drive(input logic h, input logic v, input logic b);
      hs = h;
      vs = v;
      blankN = b;
      @(posedge clk25);
      #1;
      sample();
   endtask

   task automatic line_cycle(input int c, input bit vlow, input bit act);
      drive(c >= HS, !vlow, act && c >= 16 && c < 56);
   endtask

   task automatic send_line(input int len, input bit vlow, input bit act);
      for (int c = 0; c < len; c++) line_cycle(c, vlow, act);
   endtask

   task automatic send_lines(input int first, input int last, input int long_line, input int vsl);
      for (int l = first; l <= last; l++)
         send_line((l == long_line) ? HT + 1 : HT, l < vsl, l >= 4 && l < 20);
   endtask

   task automatic send_frame(input int vsl);
      send_lines(0, VT - 1, -1, vsl);
   endtask

   task automatic clear_stats();
      pv_count = 0; x_max = 0; y_max = 0; ls_count = 0; lol_count = 0;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (5) drive(1'b1, 1'b1, 1'b0);
      vectors++;
      if (out_vec !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h expected 0", out_vec);
      end else $display("ok   reset_outputs");
      rstN = 1'b1;
   endtask

   task automatic test_nominal_lock();
      fs_count = 0; lock_at = 0; clear_stats();
      send_frame(VS);
      send_frame(VS);
      vectors++;
      if (locked !== 1'b0) begin
         miscompares++; $display("FAIL early_lock: locked=%b expected 0", locked);
      end else $display("ok   early_lock");
      clear_stats();
      send_frame(VS);
      vectors++;
      if (lock_at !== 3) begin
         miscompares++; $display("FAIL lock_fall: locked rose at vs fall %0d expected 3", lock_at);
      end else $display("ok   lock_fall");
      vectors++;
      if (locked !== 1'b1) begin
         miscompares++; $display("FAIL locked_nominal: got %b expected 1", locked);
      end else $display("ok   locked_nominal");
      vectors++;
      if (pv_count !== 640) begin
         miscompares++; $display("FAIL pixel_count: got %0d expected 640", pv_count);
      end else $display("ok   pixel_count");
      vectors++;
      if (x_max !== 39) begin
         miscompares++; $display("FAIL x_max: got %0d expected 39", x_max);
      end else $display("ok   x_max");
      vectors++;
      if (y_max !== 15) begin
         miscompares++; $display("FAIL y_max: got %0d expected 15", y_max);
      end else $display("ok   y_max");
      vectors++;
      if (ls_count !== VT) begin
         miscompares++; $display("FAIL line_starts: got %0d expected %0d", ls_count, VT);
      end else $display("ok   line_starts");
      vectors++;
      if ({hTotalMeas, hSyncMeas, vTotalMeas, vSyncMeas} !== {10'd64, 10'd8, 10'd24, 10'd2}) begin
         miscompares++;
         $display("FAIL measures: got %0d/%0d/%0d/%0d expected 64/8/24/2",
                  hTotalMeas, hSyncMeas, vTotalMeas, vSyncMeas);
      end else $display("ok   measures");
      vectors++;
      if (lol_count !== 0) begin
         miscompares++; $display("FAIL nominal_loss: got %0d pulses expected 0", lol_count);
      end else $display("ok   nominal_loss");
   endtask

   task automatic test_simultaneous();
      fs_with_ls = 1'b0; y_at_fs = 99; vt_at_fs = 0;
      send_lines(0, 0, -1, VS);
      vectors++;
      if (fs_with_ls !== 1'b1) begin
         miscompares++; $display("FAIL pulses_together: lineStart=%b expected 1", fs_with_ls);
      end else $display("ok   pulses_together");
      vectors++;
      if (y_at_fs !== 0) begin
         miscompares++; $display("FAIL y_clear: got %0d expected 0", y_at_fs);
      end else $display("ok   y_clear");
      vectors++;
      if (vt_at_fs !== VT) begin
         miscompares++; $display("FAIL vtotal_same_cycle: got %0d expected %0d", vt_at_fs, VT);
      end else $display("ok   vtotal_same_cycle");
   endtask

   task automatic test_long_line();
      clear_stats();
      send_lines(1, 11, 10, VS);
      vectors++;
      if (hTotalMeas !== 10'd65) begin
         miscompares++; $display("FAIL long_htotal: got %0d expected 65", hTotalMeas);
      end else $display("ok   long_htotal");
      vectors++;
      if (locked !== 1'b1 || lol_count !== 0) begin
         miscompares++;
         $display("FAIL hold_until_vs: locked=%b pulses=%0d expected 1/0", locked, lol_count);
      end else $display("ok   hold_until_vs");
      send_lines(12, 23, -1, VS);
      send_lines(0, 0, -1, VS);
      vectors++;
      if (lol_count !== 1) begin
         miscompares++; $display("FAIL long_loss_pulse: got %0d pulses expected 1", lol_count);
      end else $display("ok   long_loss_pulse");
      vectors++;
      if (locked !== 1'b0) begin
         miscompares++; $display("FAIL long_unlocked: got %b expected 0", locked);
      end else $display("ok   long_unlocked");
      send_lines(1, 23, -1, VS);
   endtask

   task automatic test_saturation();
      fs_count = 0; lock_at = 0;
      send_frame(VS);
      send_frame(VS);
      send_frame(VS);
      vectors++;
      if (lock_at !== 3 || locked !== 1'b1) begin
         miscompares++;
         $display("FAIL relock: lock at fall %0d locked=%b expected 3/1", lock_at, locked);
      end else $display("ok   relock");
      clear_stats();
      send_line(HS + 1100, 1'b0, 1'b0);
      vectors++;
      if (lol_count !== 1) begin
         miscompares++; $display("FAIL sat_loss_pulse: got %0d pulses expected 1", lol_count);
      end else $display("ok   sat_loss_pulse");
      vectors++;
      if (locked !== 1'b0) begin
         miscompares++; $display("FAIL sat_unlocked: got %b expected 0", locked);
      end else $display("ok   sat_unlocked");
      fs_count = 0; lock_at = 0;
      send_lines(0, 0, -1, VS);
      vectors++;
      if (hTotalMeas !== 10'd1023) begin
         miscompares++; $display("FAIL sat_htotal: got %0d expected 1023", hTotalMeas);
      end else $display("ok   sat_htotal");
   endtask

   task automatic test_vsync_wide();
      send_lines(1, 23, -1, VS);
      send_frame(3);
      vectors++;
      if (vSyncMeas !== 10'd3) begin
         miscompares++; $display("FAIL vsync_wide: got %0d expected 3", vSyncMeas);
      end else $display("ok   vsync_wide");
      send_frame(VS);
      send_frame(VS);
      vectors++;
      if (locked !== 1'b0) begin
         miscompares++; $display("FAIL goodcnt_cleared: locked=%b expected 0", locked);
      end else $display("ok   goodcnt_cleared");
      send_lines(0, 0, -1, VS);
      vectors++;
      if (lock_at !== 5 || locked !== 1'b1) begin
         miscompares++;
         $display("FAIL lock_after_wide: lock at fall %0d locked=%b expected 5/1", lock_at, locked);
      end else $display("ok   lock_after_wide");
      send_lines(1, 23, -1, VS);
   endtask

   task automatic test_reset_midframe();
      send_lines(0, 9, -1, VS);
      for (int c = 0; c < 30; c++) line_cycle(c, 1'b0, 1'b1);
      rstN = 1'b0;
      for (int c = 30; c < 35; c++) line_cycle(c, 1'b0, 1'b1);
      vectors++;
      if (out_vec !== '0) begin
         miscompares++; $display("FAIL midframe_reset: got %h expected 0", out_vec);
      end else $display("ok   midframe_reset");
      rstN = 1'b1;
      clear_stats(); fs_count = 0; lock_at = 0;
      for (int c = 35; c < HT; c++) line_cycle(c, 1'b0, 1'b1);
      vectors++;
      if (ls_count !== 0 || fs_count !== 0 || lol_count !== 0) begin
         miscompares++;
         $display("FAIL no_false_edges: ls=%0d fs=%0d loss=%0d expected 0/0/0",
                  ls_count, fs_count, lol_count);
      end else $display("ok   no_false_edges");
      vectors++;
      if (pv_count !== 21 || x_max !== 20) begin
         miscompares++;
         $display("FAIL post_reset_pixels: count=%0d xmax=%0d expected 21/20", pv_count, x_max);
      end else $display("ok   post_reset_pixels");
      send_lines(11, 23, -1, VS);
      send_frame(VS);
      send_frame(VS);
      vectors++;
      if (locked !== 1'b0) begin
         miscompares++; $display("FAIL reset_early_lock: got %b expected 0", locked);
      end else $display("ok   reset_early_lock");
      send_lines(0, 0, -1, VS);
      vectors++;
      if (lock_at !== 3 || locked !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_relock: lock at fall %0d locked=%b expected 3/1", lock_at, locked);
      end else $display("ok   reset_relock");
   endtask

   initial begin
      test_reset();
      test_nominal_lock();
      test_simultaneous();
      test_long_line();
      test_saturation();
      test_vsync_wide();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
